// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU MEM-stage, host burst and dataMem signals around the data-memory arbiter.
// master = arbiter side, slave = the surrounding pipeline/host/memory.
interface dmem_arbiter_if #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 24,
    parameter int BURST_W = 8
);
    logic              cpu_mem_read;
    logic              cpu_mem_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic               host_req;
    logic               host_we;
    logic [ADDR_W-1:0]  host_addr;
    logic [BURST_W-1:0] host_len;
    logic [DATA_W-1:0]  host_wdata;
    logic               host_wready;
    logic               host_rvalid;
    logic [DATA_W-1:0]  host_rdata;
    logic               host_busy;
    logic               host_done;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_len, host_wdata,
        output host_wready, host_rvalid, host_rdata, host_busy, host_done,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport slave (
        output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_len, host_wdata,
        input  host_wready, host_rvalid, host_rdata, host_busy, host_done,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has priority, host bursts get a forced grant after MAX_WAIT
// CPU-served cycles; a one-cycle COOLDOWN after every burst guarantees the CPU a slot.
module dmem_arbiter #(
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 24,
    parameter int MAX_WAIT = 8,
    parameter int BURST_W  = 8
) (
    input  logic clk,
    input  logic reset,
    dmem_arbiter_if.master bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_COOL} state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [BURST_W-1:0] r_left;
    logic               r_we;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_rvalid;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_done;

    logic w_cpu_acc;
    logic w_burst;

    assign w_cpu_acc = bus.cpu_mem_read | bus.cpu_mem_write;
    assign w_burst   = (r_state == S_BURST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_left   <= '0;
            r_we     <= 1'b0;
            r_wait   <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.host_req) begin
                        // Grant on a free CPU slot or once the host has waited long enough.
                        if (!w_cpu_acc || r_wait == WAIT_W'(MAX_WAIT)) begin
                            r_state <= S_BURST;
                            r_addr  <= bus.host_addr;
                            r_left  <= (bus.host_len == '0) ? BURST_W'(1) : bus.host_len;
                            r_we    <= bus.host_we;
                            r_wait  <= '0;
                        end else begin
                            r_wait <= r_wait + WAIT_W'(1);
                        end
                    end else begin
                        r_wait <= '0;
                    end
                end
                S_BURST: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_left <= r_left - BURST_W'(1);
                    if (!r_we) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= bus.mem_rdata;
                    end
                    if (r_left == BURST_W'(1)) begin
                        r_state <= S_COOL;
                        r_done  <= 1'b1;
                    end
                end
                S_COOL:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = w_burst ? r_addr          : bus.cpu_addr;
    assign bus.mem_wdata = w_burst ? bus.host_wdata  : bus.cpu_wdata;
    assign bus.mem_we    = w_burst ? r_we            : bus.cpu_mem_write;
    assign bus.mem_re    = w_burst ? !r_we           : bus.cpu_mem_read;

    assign bus.cpu_rdata   = bus.mem_rdata;
    assign bus.cpu_stall   = w_burst & w_cpu_acc;
    assign bus.host_wready = w_burst & r_we;
    assign bus.host_rvalid = r_rvalid;
    assign bus.host_rdata  = r_rdata;
    assign bus.host_busy   = (r_state != S_IDLE);
    assign bus.host_done   = r_done;
endmodule
